// File: rtl/rob_pkg.sv
// Shared widths, entry-type encoding and the tag-advance helper for the reorder buffer.
// Tag 0 is reserved as "no producer", so tags advance 1..15 and then wrap back to 1.
package rob_pkg;

    localparam int IDWidth      = 32;
    localparam int RegWidth     = 5;
    localparam int ROBWidth     = 4;
    localparam int ROBCount     = 1 << ROBWidth;
    localparam int ROBTypeWidth = 2;

    typedef enum logic [ROBTypeWidth-1:0] {
        ROB_REG = 2'b00,
        ROB_BR  = 2'b01,
        ROB_ST  = 2'b10
    } rob_type_e;

    function automatic logic [ROBWidth-1:0] next_tag(input logic [ROBWidth-1:0] tag);
        return (tag == ROBWidth'(ROBCount - 1)) ? ROBWidth'(1) : tag + ROBWidth'(1);
    endfunction

endpackage

// File: rtl/rob_if.sv
// Bundle of the dispatcher, writeback, commit and flush signals around the reorder buffer.
// The slave modport is the ROB side; the master modport is the core/bench side.
interface rob_if;
    import rob_pkg::*;

    logic                    dispatcher_rob_en_in;
    logic [ROBTypeWidth-1:0] dispatcher_rob_type_in;
    logic [RegWidth-1:0]     dispatcher_rob_rd_in;
    logic [ROBWidth-1:0]     rob_dispatcher_b_out;
    logic                    rob_dispatcher_full_out;

    logic [ROBWidth-1:0]     dispatcher_rob_rs_h_in;
    logic [ROBWidth-1:0]     dispatcher_rob_rt_h_in;
    logic                    rob_dispatcher_rs_ready_out;
    logic                    rob_dispatcher_rt_ready_out;
    logic [IDWidth-1:0]      rob_dispatcher_rs_value_out;
    logic [IDWidth-1:0]      rob_dispatcher_rt_value_out;

    logic                    alu_rob_en_in;
    logic [ROBWidth-1:0]     alu_rob_h_in;
    logic [IDWidth-1:0]      alu_rob_value_in;
    logic                    alu_rob_jump_in;
    logic [IDWidth-1:0]      alu_rob_pc_in;

    logic                    lsb_rob_en_in;
    logic [ROBWidth-1:0]     lsb_rob_h_in;
    logic [IDWidth-1:0]      lsb_rob_value_in;

    logic                    rob_regfile_en_out;
    logic [RegWidth-1:0]     rob_regfile_d_out;
    logic [IDWidth-1:0]      rob_regfile_value_out;
    logic [ROBWidth-1:0]     rob_regfile_h_out;
    logic                    rob_regfile_rst_out;

    logic                    rob_lsb_commit_out;
    logic [ROBWidth-1:0]     rob_lsb_h_out;

    logic                    rob_flush_out;
    logic [IDWidth-1:0]      rob_pc_out;

    modport master (
        output dispatcher_rob_en_in, dispatcher_rob_type_in, dispatcher_rob_rd_in,
        output dispatcher_rob_rs_h_in, dispatcher_rob_rt_h_in,
        output alu_rob_en_in, alu_rob_h_in, alu_rob_value_in, alu_rob_jump_in, alu_rob_pc_in,
        output lsb_rob_en_in, lsb_rob_h_in, lsb_rob_value_in,
        input  rob_dispatcher_b_out, rob_dispatcher_full_out,
        input  rob_dispatcher_rs_ready_out, rob_dispatcher_rt_ready_out,
        input  rob_dispatcher_rs_value_out, rob_dispatcher_rt_value_out,
        input  rob_regfile_en_out, rob_regfile_d_out, rob_regfile_value_out, rob_regfile_h_out,
        input  rob_regfile_rst_out, rob_lsb_commit_out, rob_lsb_h_out,
        input  rob_flush_out, rob_pc_out
    );

    modport slave (
        input  dispatcher_rob_en_in, dispatcher_rob_type_in, dispatcher_rob_rd_in,
        input  dispatcher_rob_rs_h_in, dispatcher_rob_rt_h_in,
        input  alu_rob_en_in, alu_rob_h_in, alu_rob_value_in, alu_rob_jump_in, alu_rob_pc_in,
        input  lsb_rob_en_in, lsb_rob_h_in, lsb_rob_value_in,
        output rob_dispatcher_b_out, rob_dispatcher_full_out,
        output rob_dispatcher_rs_ready_out, rob_dispatcher_rt_ready_out,
        output rob_dispatcher_rs_value_out, rob_dispatcher_rt_value_out,
        output rob_regfile_en_out, rob_regfile_d_out, rob_regfile_value_out, rob_regfile_h_out,
        output rob_regfile_rst_out, rob_lsb_commit_out, rob_lsb_h_out,
        output rob_flush_out, rob_pc_out
    );

endinterface

// File: rtl/rob.sv
// Reorder buffer: 15-entry circular queue of in-flight instructions, in-order single retire,
// operand lookup with ALU/LSB bypass, and misprediction flush driven from the branch at head.
module rob
    import rob_pkg::*;
(
    input logic clk_in,
    input logic rst_in,
    input logic rdy_in,
    rob_if.slave bus
);

    logic [ROBWidth-1:0] head_q;
    logic [ROBWidth-1:0] tail_q;
    logic [ROBWidth-1:0] count_q;

    rob_type_e           type_q  [ROBCount];
    logic [RegWidth-1:0] rd_q    [ROBCount];
    logic [IDWidth-1:0]  value_q [ROBCount];
    logic [IDWidth-1:0]  pc_q    [ROBCount];
    logic [ROBCount-1:0] ready_q;
    logic [ROBCount-1:0] jump_q;

    logic      full;
    logic      alloc;
    logic      alu_wb;
    logic      lsb_wb;
    logic      commit;
    logic      flush;
    logic      reg_write;
    logic      st_commit;
    rob_type_e head_type;

    assign full      = (count_q == ROBWidth'(ROBCount - 1));
    assign alu_wb    = rdy_in && bus.alu_rob_en_in && (bus.alu_rob_h_in != '0);
    assign lsb_wb    = rdy_in && bus.lsb_rob_en_in && (bus.lsb_rob_h_in != '0);

    // Commit looks only at the stored ready bit, so a same-cycle writeback to head waits a cycle.
    assign head_type = type_q[head_q];
    assign commit    = rdy_in && (count_q != '0) && ready_q[head_q];
    assign flush     = commit && (head_type == ROB_BR) && jump_q[head_q];
    assign reg_write = commit && (head_type != ROB_ST) && (rd_q[head_q] != '0);
    assign st_commit = commit && (head_type == ROB_ST);
    assign alloc     = rdy_in && bus.dispatcher_rob_en_in && !full && !flush;

    assign bus.rob_dispatcher_b_out    = tail_q;
    assign bus.rob_dispatcher_full_out = full;

    assign bus.rob_regfile_en_out    = reg_write;
    assign bus.rob_regfile_d_out     = reg_write ? rd_q[head_q] : '0;
    assign bus.rob_regfile_value_out = reg_write ? value_q[head_q] : '0;
    assign bus.rob_regfile_h_out     = reg_write ? head_q : '0;
    assign bus.rob_regfile_rst_out   = flush;
    assign bus.rob_lsb_commit_out    = st_commit;
    assign bus.rob_lsb_h_out         = st_commit ? head_q : '0;
    assign bus.rob_flush_out         = flush;
    assign bus.rob_pc_out            = flush ? pc_q[head_q] : '0;

    logic [ROBWidth-1:0] q_tag   [2];
    logic [1:0]          q_ready;
    logic [IDWidth-1:0]  q_value [2];

    assign q_tag[0] = bus.dispatcher_rob_rs_h_in;
    assign q_tag[1] = bus.dispatcher_rob_rt_h_in;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            q_ready[p] = 1'b0;
            q_value[p] = '0;
            if (q_tag[p] != '0) begin
                if (alu_wb && (bus.alu_rob_h_in == q_tag[p])) begin
                    q_ready[p] = 1'b1;
                    q_value[p] = bus.alu_rob_value_in;
                end else if (lsb_wb && (bus.lsb_rob_h_in == q_tag[p])) begin
                    q_ready[p] = 1'b1;
                    q_value[p] = bus.lsb_rob_value_in;
                end else if (ready_q[q_tag[p]]) begin
                    q_ready[p] = 1'b1;
                    q_value[p] = value_q[q_tag[p]];
                end
            end
        end
    end

    assign bus.rob_dispatcher_rs_ready_out = q_ready[0];
    assign bus.rob_dispatcher_rt_ready_out = q_ready[1];
    assign bus.rob_dispatcher_rs_value_out = q_value[0];
    assign bus.rob_dispatcher_rt_value_out = q_value[1];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q  <= ROBWidth'(1);
            tail_q  <= ROBWidth'(1);
            count_q <= '0;
            ready_q <= '0;
            jump_q  <= '0;
            for (int i = 0; i < ROBCount; i++) begin
                type_q[i]  <= ROB_REG;
                rd_q[i]    <= '0;
                value_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else if (rdy_in) begin
            if (flush) begin
                head_q  <= ROBWidth'(1);
                tail_q  <= ROBWidth'(1);
                count_q <= '0;
                ready_q <= '0;
                jump_q  <= '0;
            end else begin
                if (alloc) begin
                    type_q[tail_q]  <= rob_type_e'(bus.dispatcher_rob_type_in);
                    rd_q[tail_q]    <= bus.dispatcher_rob_rd_in;
                    ready_q[tail_q] <= 1'b0;
                    jump_q[tail_q]  <= 1'b0;
                    tail_q          <= next_tag(tail_q);
                end
                if (alu_wb) begin
                    ready_q[bus.alu_rob_h_in] <= 1'b1;
                    value_q[bus.alu_rob_h_in] <= bus.alu_rob_value_in;
                    jump_q[bus.alu_rob_h_in]  <= bus.alu_rob_jump_in;
                    pc_q[bus.alu_rob_h_in]    <= bus.alu_rob_pc_in;
                end
                if (lsb_wb) begin
                    ready_q[bus.lsb_rob_h_in] <= 1'b1;
                    value_q[bus.lsb_rob_h_in] <= bus.lsb_rob_value_in;
                end
                if (commit) begin
                    head_q <= next_tag(head_q);
                end
                count_q <= count_q + ROBWidth'(alloc) - ROBWidth'(commit);
            end
        end
    end

endmodule

// File: tb/tb_rob.sv
// Directed testbench for the reorder buffer: allocation/wrap, in-order commit, bypassed lookup,
// branch flush, store commit, global stall and mid-stream reset.
module tb_rob;
    import rob_pkg::*;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;

    rob_if bus ();

    rob dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus.slave)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change just after the falling edge, well away from the rising edge.
    task automatic cyc();
        @(negedge clk_in);
        bus.dispatcher_rob_en_in = 1'b0;
        bus.alu_rob_en_in        = 1'b0;
        bus.alu_rob_jump_in      = 1'b0;
        bus.lsb_rob_en_in        = 1'b0;
    endtask

    task automatic set_alloc(input rob_type_e t, input logic [4:0] rd);
        bus.dispatcher_rob_en_in   = 1'b1;
        bus.dispatcher_rob_type_in = t;
        bus.dispatcher_rob_rd_in   = rd;
    endtask

    task automatic alloc(input rob_type_e t, input logic [4:0] rd);
        set_alloc(t, rd);
        cyc();
    endtask

    task automatic set_alu(input logic [3:0] h, input logic [31:0] v, input logic j, input logic [31:0] pc);
        bus.alu_rob_en_in    = 1'b1;
        bus.alu_rob_h_in     = h;
        bus.alu_rob_value_in = v;
        bus.alu_rob_jump_in  = j;
        bus.alu_rob_pc_in    = pc;
    endtask

    task automatic set_lsb(input logic [3:0] h, input logic [31:0] v);
        bus.lsb_rob_en_in    = 1'b1;
        bus.lsb_rob_h_in     = h;
        bus.lsb_rob_value_in = v;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        cyc();
        rst_in = 1'b0;
    endtask

    task automatic chk_commit(input string tag, input logic [4:0] d, input logic [31:0] v, input logic [3:0] h);
        chk({tag, "_en"}, 32'(bus.rob_regfile_en_out), 1);
        chk({tag, "_d"}, 32'(bus.rob_regfile_d_out), 32'(d));
        chk({tag, "_val"}, bus.rob_regfile_value_out, v);
        chk({tag, "_h"}, 32'(bus.rob_regfile_h_out), 32'(h));
    endtask

    initial begin
        rst_in = 1'b1;
        rdy_in = 1'b1;
        bus.dispatcher_rob_en_in   = 1'b0;
        bus.dispatcher_rob_type_in = ROB_REG;
        bus.dispatcher_rob_rd_in   = '0;
        bus.dispatcher_rob_rs_h_in = '0;
        bus.dispatcher_rob_rt_h_in = '0;
        bus.alu_rob_en_in          = 1'b0;
        bus.alu_rob_h_in           = '0;
        bus.alu_rob_value_in       = '0;
        bus.alu_rob_jump_in        = 1'b0;
        bus.alu_rob_pc_in          = '0;
        bus.lsb_rob_en_in          = 1'b0;
        bus.lsb_rob_h_in           = '0;
        bus.lsb_rob_value_in       = '0;
        repeat (2) cyc();
        rst_in = 1'b0;
        #1;
        chk("rst_b_out", 32'(bus.rob_dispatcher_b_out), 1);
        chk("rst_full", 32'(bus.rob_dispatcher_full_out), 0);
        chk("rst_rf_en", 32'(bus.rob_regfile_en_out), 0);
        chk("rst_flush", 32'(bus.rob_flush_out), 0);
        chk("rst_lsb_commit", 32'(bus.rob_lsb_commit_out), 0);
        chk("rst_pc", bus.rob_pc_out, 0);
        chk("rst_count", 32'(dut.count_q), 0);

        // Single REG instruction: allocate, write back, commit next cycle.
        set_alloc(ROB_REG, 5'd5);
        #1 chk("t1_alloc_tag", 32'(bus.rob_dispatcher_b_out), 1);
        cyc();
        set_alu(4'd1, 32'h2A, 1'b0, 32'h0);
        bus.dispatcher_rob_rs_h_in = 4'd1;
        #1;
        chk("t1_bypass_ready", 32'(bus.rob_dispatcher_rs_ready_out), 1);
        chk("t1_bypass_val", bus.rob_dispatcher_rs_value_out, 32'h2A);
        chk("t1_no_same_cycle_commit", 32'(bus.rob_regfile_en_out), 0);
        cyc();
        #1 chk_commit("t1_commit", 5'd5, 32'h2A, 4'd1);
        cyc();
        #1;
        chk("t1_count", 32'(dut.count_q), 0);
        chk("t1_rf_en_pulse", 32'(bus.rob_regfile_en_out), 0);

        // Fill to 15, refuse the 16th, free one, then wrap to tag 1.
        do_reset();
        for (int i = 1; i <= 15; i++) begin
            set_alloc(ROB_REG, 5'(i));
            #1 chk("t2_fill_tag", 32'(bus.rob_dispatcher_b_out), 32'(i));
            cyc();
        end
        #1;
        chk("t2_full", 32'(bus.rob_dispatcher_full_out), 1);
        chk("t2_tail_wrap", 32'(bus.rob_dispatcher_b_out), 1);
        set_alloc(ROB_REG, 5'd20);
        cyc();
        #1;
        chk("t2_16th_count", 32'(dut.count_q), 15);
        chk("t2_16th_tail", 32'(bus.rob_dispatcher_b_out), 1);
        set_alu(4'd1, 32'h11, 1'b0, 32'h0);
        cyc();
        #1 chk_commit("t2_commit", 5'd1, 32'h11, 4'd1);
        cyc();
        #1;
        chk("t2_not_full", 32'(bus.rob_dispatcher_full_out), 0);
        chk("t2_next_tag", 32'(bus.rob_dispatcher_b_out), 1);
        alloc(ROB_REG, 5'd7);
        #1;
        chk("t2_after_wrap_tag", 32'(bus.rob_dispatcher_b_out), 2);
        chk("t2_full_again", 32'(bus.rob_dispatcher_full_out), 1);

        // Out-of-order writeback, in-order commit.
        do_reset();
        alloc(ROB_REG, 5'd3);
        alloc(ROB_REG, 5'd4);
        set_lsb(4'd2, 32'hB2);
        cyc();
        bus.dispatcher_rob_rt_h_in = 4'd2;
        #1;
        chk("t3_head_blocks", 32'(bus.rob_regfile_en_out), 0);
        chk("t3_stored_ready", 32'(bus.rob_dispatcher_rt_ready_out), 1);
        chk("t3_stored_val", bus.rob_dispatcher_rt_value_out, 32'hB2);
        set_alu(4'd1, 32'hA1, 1'b0, 32'h0);
        cyc();
        #1 chk_commit("t3_first", 5'd3, 32'hA1, 4'd1);
        cyc();
        #1 chk_commit("t3_second", 5'd4, 32'hB2, 4'd2);
        cyc();
        #1;
        chk("t3_idle", 32'(bus.rob_regfile_en_out), 0);
        chk("t3_count", 32'(dut.count_q), 0);

        // Mispredicted branch with link behind two REG entries; one younger entry is discarded.
        do_reset();
        alloc(ROB_REG, 5'd10);
        alloc(ROB_REG, 5'd11);
        alloc(ROB_BR, 5'd1);
        alloc(ROB_REG, 5'd12);
        set_alu(4'd3, 32'h44, 1'b1, 32'h100);
        set_lsb(4'd1, 32'h10);
        bus.dispatcher_rob_rs_h_in = 4'd3;
        bus.dispatcher_rob_rt_h_in = 4'd1;
        #1;
        chk("t4_rs_ready", 32'(bus.rob_dispatcher_rs_ready_out), 1);
        chk("t4_rs_val", bus.rob_dispatcher_rs_value_out, 32'h44);
        chk("t4_rt_ready", 32'(bus.rob_dispatcher_rt_ready_out), 1);
        chk("t4_rt_val", bus.rob_dispatcher_rt_value_out, 32'h10);
        cyc();
        set_alu(4'd2, 32'h20, 1'b0, 32'h0);
        #1;
        chk_commit("t4_c1", 5'd10, 32'h10, 4'd1);
        chk("t4_c1_flush", 32'(bus.rob_flush_out), 0);
        cyc();
        #1;
        chk_commit("t4_c2", 5'd11, 32'h20, 4'd2);
        chk("t4_c2_flush", 32'(bus.rob_flush_out), 0);
        cyc();
        set_alloc(ROB_REG, 5'd13);
        #1;
        chk_commit("t4_br", 5'd1, 32'h44, 4'd3);
        chk("t4_rf_rst", 32'(bus.rob_regfile_rst_out), 1);
        chk("t4_flush", 32'(bus.rob_flush_out), 1);
        chk("t4_pc", bus.rob_pc_out, 32'h100);
        chk("t4_tail_before", 32'(bus.rob_dispatcher_b_out), 5);
        cyc();
        #1;
        chk("t4_flush_pulse", 32'(bus.rob_flush_out), 0);
        chk("t4_rst_pulse", 32'(bus.rob_regfile_rst_out), 0);
        chk("t4_count", 32'(dut.count_q), 0);
        chk("t4_b_out", 32'(bus.rob_dispatcher_b_out), 1);
        chk("t4_ready_cleared", 32'(bus.rob_dispatcher_rs_ready_out), 0);

        // Lookup bypass from both writeback ports and the tag-0 rule.
        alloc(ROB_REG, 5'd9);
        alloc(ROB_REG, 5'd0);
        alloc(ROB_REG, 5'd0);
        alloc(ROB_REG, 5'd6);
        set_alu(4'd4, 32'h7, 1'b0, 32'h0);
        set_lsb(4'd2, 32'h9);
        bus.dispatcher_rob_rs_h_in = 4'd4;
        bus.dispatcher_rob_rt_h_in = 4'd2;
        #1;
        chk("t5_alu_ready", 32'(bus.rob_dispatcher_rs_ready_out), 1);
        chk("t5_alu_val", bus.rob_dispatcher_rs_value_out, 32'h7);
        chk("t5_lsb_ready", 32'(bus.rob_dispatcher_rt_ready_out), 1);
        chk("t5_lsb_val", bus.rob_dispatcher_rt_value_out, 32'h9);
        bus.dispatcher_rob_rt_h_in = 4'd0;
        #1;
        chk("t5_tag0_ready", 32'(bus.rob_dispatcher_rt_ready_out), 0);
        chk("t5_tag0_val", bus.rob_dispatcher_rt_value_out, 0);
        cyc();
        #1;
        chk("t5_kept_ready", 32'(bus.rob_dispatcher_rs_ready_out), 1);
        chk("t5_kept_val", bus.rob_dispatcher_rs_value_out, 32'h7);

        // Stall with the head ready, then reset with six live entries.
        alloc(ROB_REG, 5'd14);
        alloc(ROB_REG, 5'd15);
        #1 chk("t6_six_live", 32'(dut.count_q), 6);
        set_alu(4'd1, 32'h55, 1'b0, 32'h0);
        cyc();
        rdy_in = 1'b0;
        set_alloc(ROB_REG, 5'd2);
        #1;
        chk("t6_stall_rf_en", 32'(bus.rob_regfile_en_out), 0);
        chk("t6_stall_flush", 32'(bus.rob_flush_out), 0);
        cyc();
        #1;
        chk("t6_stall_tail", 32'(bus.rob_dispatcher_b_out), 7);
        chk("t6_stall_count", 32'(dut.count_q), 6);
        rdy_in = 1'b1;
        #1 chk_commit("t6_resume", 5'd9, 32'h55, 4'd1);
        rst_in = 1'b1;
        cyc();
        #1;
        chk("t6_rst_rf_en", 32'(bus.rob_regfile_en_out), 0);
        chk("t6_rst_rf_val", bus.rob_regfile_value_out, 0);
        chk("t6_rst_b_out", 32'(bus.rob_dispatcher_b_out), 1);
        chk("t6_rst_full", 32'(bus.rob_dispatcher_full_out), 0);
        chk("t6_rst_count", 32'(dut.count_q), 0);
        chk("t6_rst_lookup", 32'(bus.rob_dispatcher_rs_ready_out), 0);
        rst_in = 1'b0;

        // Store retires to the LSB, not the regfile.
        alloc(ROB_ST, 5'd0);
        set_lsb(4'd1, 32'h0);
        cyc();
        #1;
        chk("t7_st_commit", 32'(bus.rob_lsb_commit_out), 1);
        chk("t7_st_h", 32'(bus.rob_lsb_h_out), 1);
        chk("t7_st_no_rf", 32'(bus.rob_regfile_en_out), 0);
        cyc();
        #1;
        chk("t7_st_pulse", 32'(bus.rob_lsb_commit_out), 0);
        chk("t7_count", 32'(dut.count_q), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
